maxpool2x2_stream: RTL
======================

Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the convolution layer's per-neuron output path.
- Consumes one 8-bit convolution result per handshake, in raster order (row-major), for a ROW_LEN x COL_LEN feature map.
- Emits the (ROW_LEN/2) x (COL_LEN/2) pooled map in raster order over a valid/ready handshake.
- Instantiated once per neuron, next to that neuron's output memory.

Parameters:
- WIDTH, 8, data bits per pixel; values are unsigned.
- ROW_LEN, 12, input pixels per row; must be even and >= 2.
- COL_LEN, 12, input rows per frame; must be even and >= 2.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid, input, 1, in_data holds a valid pixel.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, WIDTH, convolution output pixel.
- out_valid, output, 1, out_data holds a valid pooled pixel.
- out_ready, input, 1, consumer accepts out_data this cycle.
- out_data, output, WIDTH, pooled maximum.
- out_last, output, 1, qualifies the final pooled pixel of the frame.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse at frame completion.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters cleared; in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Line-buffer contents are don't-care.
- Handshakes: a pixel is accepted when in_valid && in_ready; a pooled pixel is taken when out_valid && out_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready). The combinational path from out_ready to in_ready is allowed.
- Counters: col counts 0..ROW_LEN-1 and row counts 0..COL_LEN-1. Both advance only on input acceptance. col wraps to 0 and increments row.
- Horizontal register h: on an even col, h <= in_data. On an odd col, pair = max(h, in_data).
- Line buffer: ROW_LEN/2 entries of WIDTH, indexed by col>>1.
  - Even row, odd col: line[col>>1] <= pair.
  - Odd row, odd col: result = max(line[col>>1], pair). out_data <= result, out_valid <= 1 on the following edge (1-cycle latency from the accepting edge).
- All comparisons are unsigned; ties keep either operand, since the value is identical.
- out_valid stays high and out_data stays stable until taken. out_valid falls on the take unless a new result is loaded on the same edge, in which case it stays high with the new data.
- out_last = 1 alongside the result produced by row==COL_LEN-1, col==ROW_LEN-1; otherwise 0.
- State machine:
  - IDLE: start -> RUN; counters cleared; busy <= 1.
  - RUN: after accepting the last pixel (row==COL_LEN-1, col==ROW_LEN-1) -> DRAIN. in_ready is 0 from then on.
  - DRAIN: when the last pooled pixel is taken -> DONE.
  - DONE: done=1 for exactly one cycle, busy <= 0, -> IDLE.
- start in RUN, DRAIN or DONE is ignored. start and reset asserted together: reset wins.
- in_valid outside RUN is ignored (in_ready=0; no pixel consumed).
- Mid-frame reset returns to IDLE immediately; any pending output is discarded (out_valid=0). The next frame requires a new start.
- Holding out_ready low stalls input indefinitely; no data is lost or duplicated.

Test Plan:
- ROW_LEN=4, COL_LEN=4; pulse start; stream 0..15 with in_valid=1, out_ready=1 -> outputs 5, 7, 13, 15 in order. out_last only with 15. done pulses exactly once, one cycle after 15 is taken; busy then 0.
- Same frame with out_ready held 0 after the first output -> out_valid stays 1 with out_data=5, in_ready=0, and no further pixels are accepted. Releasing out_ready -> the remaining outputs are 7, 13, 15 with no loss or duplication.
- Unsigned check: window {0xFF, 0x01, 0x80, 0x7F} -> output 0xFF. Window {0x00, 0x00, 0x00, 0x00} -> 0x00.
- Random in_valid gaps (around 50%) plus random out_ready on a 12x12 frame -> the 36 outputs match the software max-pool model, in order, with out_last on the 36th only.
- Assert reset low after 7 accepted pixels -> all outputs return to reset values asynchronously. A new start and full 4x4 frame then yields 5, 7, 13, 15 exactly.
- Pulse start again while busy -> ignored: the frame still completes with a single done, and no counter restart occurs.

Source files
------------

// File: rtl/maxpool2x2_stream.sv
// ---------------------------------------------------------------------------
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 max-pooling stage. Accepts a ROW_LEN x COL_LEN
//   feature map of unsigned pixels in raster order and emits the
//   (ROW_LEN/2) x (COL_LEN/2) pooled map in raster order.
//
//   A horizontal register holds the left pixel of each pair. On even rows the
//   pair maximum is parked in a half-row line buffer. On odd rows it is
//   combined with the parked value to form the window maximum.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : one-cycle pulse, begins a frame (honoured only in IDLE)
//   in_valid   : in_data holds a valid pixel
//   in_ready   : block accepts in_data this cycle
//   in_data    : convolution output pixel (unsigned)
//   out_valid  : out_data holds a pooled pixel
//   out_ready  : consumer takes out_data this cycle
//   out_data   : pooled maximum
//   out_last   : marks the final pooled pixel of the frame
//   busy       : high from accepted start until done
//   done       : one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module maxpool2x2_stream #(
  parameter int WIDTH   = 8,
  parameter int ROW_LEN = 12,
  parameter int COL_LEN = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int CW   = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
  localparam int RW   = (COL_LEN > 2) ? $clog2(COL_LEN) : 1;
  localparam int HALF = ROW_LEN / 2;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [WIDTH-1:0] r_h;
  logic [WIDTH-1:0] r_line [HALF];
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_busy;

  logic             w_accept;
  logic             w_take;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_last_pix;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_pair;
  logic [WIDTH-1:0] w_line_rd;
  logic [WIDTH-1:0] w_result;
  logic             w_load;
  logic             w_park;

  // Input is only blocked when a result is waiting and the consumer is not
  // taking it this cycle; a take frees the slot for a result loaded on the
  // same edge, so back-to-back streaming never stalls.
  assign in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_take     = r_out_valid && out_ready;

  assign w_col_last = (r_col == CW'(ROW_LEN - 1));
  assign w_row_last = (r_row == RW'(COL_LEN - 1));
  assign w_last_pix = w_col_last && w_row_last;

  assign w_idx      = IW'(r_col >> 1);
  assign w_pair     = (r_h > in_data) ? r_h : in_data;
  assign w_line_rd  = r_line[w_idx];
  assign w_result   = (w_line_rd > w_pair) ? w_line_rd : w_pair;

  // Odd column closes a horizontal pair: even rows park it, odd rows finish
  // the 2x2 window.
  assign w_park     = w_accept && r_col[0] && !r_row[0];
  assign w_load     = w_accept && r_col[0] &&  r_row[0];

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign busy       = r_busy;
  assign done       = (r_state == S_DONE);

  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last_pix) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_take && r_out_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_h         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end

      if (w_accept) begin
        if (!r_col[0]) r_h <= in_data;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      // A load on the same edge as a take keeps out_valid high with new data.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_last  <= w_last_pix;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  // NOTE: the line buffer has no reset; every entry is written on an even row
  // before any odd row reads it, so its power-up contents never matter.
  always_ff @(posedge clock) begin
    if (w_park) r_line[w_idx] <= w_pair;
  end

endmodule
